// File: rtl/fp_native_pkg.sv
// Shared native-format definitions: 81-bit native word field positions,
// exponent constants and the load-convert state encoding.
package fp_native_pkg;

    localparam int IN_W     = 80;
    localparam int NATIVE_W = 81;
    localparam int MANT_W   = 64;
    localparam int EXP_W    = 15;
    localparam int EXP16_W  = 16;

    localparam int IN_SIGN_BIT = 79;
    localparam int IN_EXP_MSB  = 78;
    localparam int IN_EXP_LSB  = 64;

    localparam int OUT_SIGN_BIT   = 80;
    localparam int OUT_EXP_LO_MSB = 79;
    localparam int OUT_EXP_LO_LSB = 65;
    localparam int OUT_EXP_HI_BIT = 64;
    localparam int MANT_MSB       = 63;

    localparam logic [EXP16_W-1:0] EXP_OFF      = 16'h4000;
    localparam logic [EXP16_W-1:0] EXP_UNORD    = 16'hFFFF;
    localparam logic [EXP16_W-1:0] EXP_DEN_BASE = 16'h4001;
    localparam logic [EXP_W-1:0]   EXP_IN_MAX   = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        HOLD
    } state_t;

    // The top exponent bit lives below the low fifteen bits in the native word.
    function automatic logic [NATIVE_W-1:0] pack_native(input logic               sign,
                                                        input logic [EXP16_W-1:0] exp16,
                                                        input logic [MANT_W-1:0]  mant);
        logic [NATIVE_W-1:0] w;
        w = '0;
        w[OUT_SIGN_BIT]                   = sign;
        w[OUT_EXP_LO_MSB:OUT_EXP_LO_LSB]  = exp16[EXP_W-1:0];
        w[OUT_EXP_HI_BIT]                 = exp16[EXP16_W-1];
        w[MANT_MSB:0]                     = mant;
        return w;
    endfunction

endpackage

// File: rtl/lde_norm_step.sv
// One denormal normalization step: shift left by 8 while the top byte is
// empty, else by 1, decrementing exp16 to match. Exists only when
// LDE_DENORM_NORMALIZE_EN is defined.
`ifdef LDE_DENORM_NORMALIZE_EN
module lde_norm_step
    import fp_native_pkg::*;
(
    input  logic [MANT_W-1:0]  mant,
    input  logic [EXP16_W-1:0] exp16,
    output logic [MANT_W-1:0]  mant_next,
    output logic [EXP16_W-1:0] exp_next,
    output logic               done
);

    always_comb begin
        if (mant[MANT_MSB -: 8] == 8'h00) begin
            mant_next = mant << 8;
            exp_next  = exp16 - 16'd8;
        end else begin
            mant_next = mant << 1;
            exp_next  = exp16 - 16'd1;
        end
    end

    assign done = mant_next[MANT_MSB];

endmodule
`endif

// File: rtl/lde_load_convert.sv
// Converts 80-bit memory extended operands into the 81-bit native format.
// Define LDE_DENORM_NORMALIZE_EN to normalize denormals; otherwise they flush to zero.
module lde_load_convert
    import fp_native_pkg::*;
#(
    parameter int TAG_W = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NATIVE_W-1:0] out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_den
);

    state_t state, state_next;

    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [MANT_W-1:0]   in_mant;
    logic                transfer;
    logic                conv_den;
    logic                conv_needs_norm;
    logic [NATIVE_W-1:0] conv_word;

    assign in_sign = in_data[IN_SIGN_BIT];
    assign in_exp  = in_data[IN_EXP_MSB:IN_EXP_LSB];
    assign in_mant = in_data[MANT_MSB:0];

    // A new operand may enter whenever the output slot is free or being drained.
    assign in_ready = rst_n && (state != NORM) && (!out_valid || out_ready);
    assign transfer = in_valid && in_ready;

    always_comb begin
        conv_den        = (in_exp == '0) && (in_mant != '0);
        conv_needs_norm = 1'b0;
        conv_word       = '0;
        if (in_exp == EXP_IN_MAX) begin
            conv_word = pack_native(in_sign, EXP_UNORD, in_mant);
        end else if (in_exp == '0) begin
            if (in_mant == '0) begin
                conv_word = pack_native(in_sign, '0, '0);
`ifdef LDE_DENORM_NORMALIZE_EN
            end else begin
                conv_word       = pack_native(in_sign, EXP_DEN_BASE, in_mant);
                conv_needs_norm = !in_mant[MANT_MSB];
`endif
            end
        end else begin
            conv_word = pack_native(in_sign, {1'b0, in_exp} + EXP_OFF, in_mant);
        end
    end

`ifdef LDE_DENORM_NORMALIZE_EN
    logic                norm_sign;
    logic [EXP16_W-1:0]  norm_exp;
    logic [MANT_W-1:0]   norm_mant;
    logic [EXP16_W-1:0]  step_exp;
    logic [MANT_W-1:0]   step_mant;
    logic                step_done;

    lde_norm_step u_norm_step (
        .mant      (norm_mant),
        .exp16     (norm_exp),
        .mant_next (step_mant),
        .exp_next  (step_exp),
        .done      (step_done)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = conv_needs_norm ? NORM : HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_next = conv_needs_norm ? NORM : HOLD;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            NORM: begin
`ifdef LDE_DENORM_NORMALIZE_EN
                if (step_done) begin
                    state_next = HOLD;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Tag and denormal flag are captured at acceptance; during NORM they are
    // not yet visible because out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_den   <= 1'b0;
`ifdef LDE_DENORM_NORMALIZE_EN
            norm_sign <= 1'b0;
            norm_exp  <= '0;
            norm_mant <= '0;
`endif
        end else if (transfer) begin
            out_tag <= in_tag;
            out_den <= conv_den;
`ifdef LDE_DENORM_NORMALIZE_EN
            if (conv_needs_norm) begin
                out_valid <= 1'b0;
                norm_sign <= in_sign;
                norm_exp  <= EXP_DEN_BASE;
                norm_mant <= in_mant;
            end else
`endif
            begin
                out_valid <= 1'b1;
                out_data  <= conv_word;
            end
`ifdef LDE_DENORM_NORMALIZE_EN
        end else if (state == NORM) begin
            norm_exp  <= step_exp;
            norm_mant <= step_mant;
            if (step_done) begin
                out_valid <= 1'b1;
                out_data  <= pack_native(norm_sign, step_exp, step_mant);
            end
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lde_load_convert.sv
// Directed self-checking bench for lde_load_convert; expectations follow
// LDE_DENORM_NORMALIZE_EN when it is defined.
module tb_lde_load_convert;

    localparam int TAG_W = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [79:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [80:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_den;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lde_load_convert #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_den   (out_den)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0h required %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [80:0] native(input logic s, input logic [15:0] e, input logic [63:0] m);
        return {s, e[14:0], e[15], m};
    endfunction

    function automatic logic [79:0] mem(input logic s, input logic [14:0] e, input logic [63:0] m);
        return {s, e, m};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one operand and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [79:0] d, input logic [TAG_W-1:0] t);
        int n = 0;
        in_data  = d;
        in_tag   = t;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) checkOutput("ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic runNormal(input string name, input logic [79:0] d, input logic [TAG_W-1:0] t,
                             input logic [80:0] word, input logic den);
        applyStimulus(d, t);
        checkOutput(name, {out_valid, out_den, out_tag, out_data}, {1'b1, den, t, word});
        tick();
        checkOutput({name, "_drain"}, out_valid, 1'b0);
    endtask

    task automatic runDenorm(input string name, input logic [79:0] d, input logic [TAG_W-1:0] t,
                             input logic [80:0] word, input int ncycles);
        int c = 0;
        applyStimulus(d, t);
        if (ncycles > 0) checkOutput({name, "_in_norm"}, {in_ready, out_valid}, 2'b00);
        while (!out_valid && c < 40) begin
            tick();
            c++;
        end
        checkOutput({name, "_cycles"}, c, ncycles);
        checkOutput(name, {out_valid, out_den, out_tag, out_data}, {1'b1, 1'b1, t, word});
        tick();
        checkOutput({name, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [80:0] stall_word;
        logic [79:0] vin  [10];
        logic [80:0] vexp [10];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {in_ready, out_valid, out_den, out_tag, out_data}, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_release", in_ready, 1'b1);

        out_ready = 1'b1;
        runNormal("normal_3fff", mem(1'b0, 15'h3FFF, 64'h8000_0000_0000_0000), 9'h001,
                  native(1'b0, 16'h7FFF, 64'h8000_0000_0000_0000), 1'b0);
        runNormal("unordered", mem(1'b0, 15'h7FFF, 64'hC000_0000_0000_0000), 9'h002,
                  native(1'b0, 16'hFFFF, 64'hC000_0000_0000_0000), 1'b0);
        runNormal("neg_zero", mem(1'b1, 15'h0000, 64'h0), 9'h003,
                  native(1'b1, 16'h0000, 64'h0), 1'b0);
        runNormal("unnormal_exp1", mem(1'b0, 15'h0001, 64'h0000_0000_1234_5678), 9'h004,
                  native(1'b0, 16'h4001, 64'h0000_0000_1234_5678), 1'b0);
        runNormal("exp_7ffe", mem(1'b1, 15'h7FFE, 64'hFFFF_FFFF_FFFF_FFFF), 9'h005,
                  native(1'b1, 16'hBFFE, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0);

`ifdef LDE_DENORM_NORMALIZE_EN
        runDenorm("den_mant1", mem(1'b1, 15'h0, 64'h1), 9'h015,
                  native(1'b1, 16'h3FC2, 64'h8000_0000_0000_0000), 14);
        runDenorm("den_shift8", mem(1'b0, 15'h0, 64'h0080_0000_0000_0000), 9'h011,
                  native(1'b0, 16'h3FF9, 64'h8000_0000_0000_0000), 1);
        runDenorm("den_shift1", mem(1'b0, 15'h0, 64'h4000_0000_0000_0000), 9'h012,
                  native(1'b0, 16'h4000, 64'h8000_0000_0000_0000), 1);
        runDenorm("pseudo_den", mem(1'b1, 15'h0, 64'h8000_0000_0000_0001), 9'h013,
                  native(1'b1, 16'h4001, 64'h8000_0000_0000_0001), 0);
`else
        runDenorm("den_mant1", mem(1'b1, 15'h0, 64'h1), 9'h015, 81'h0, 0);
        runDenorm("den_shift8", mem(1'b0, 15'h0, 64'h0080_0000_0000_0000), 9'h011, 81'h0, 0);
        runDenorm("pseudo_den", mem(1'b1, 15'h0, 64'h8000_0000_0000_0001), 9'h013, 81'h0, 0);
`endif

        out_ready  = 1'b0;
        stall_word = native(1'b0, 16'h5234, 64'h9ABC_DEF0_1234_5678);
        applyStimulus(mem(1'b0, 15'h1234, 64'h9ABC_DEF0_1234_5678), 9'h0AA);
        checkOutput("stall_first", {in_ready, out_valid, out_den, out_tag, out_data},
                    {1'b0, 1'b1, 1'b0, 9'h0AA, stall_word});
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_hold", {in_ready, out_valid, out_den, out_tag, out_data},
                        {1'b0, 1'b1, 1'b0, 9'h0AA, stall_word});
        end
        out_ready = 1'b1;
        tick();
        checkOutput("stall_drain", out_valid, 1'b0);

        for (int i = 0; i < 10; i++) begin
            vin[i]  = mem(i[0], 15'h2000 + 15'(i), 64'hC000_0000_0000_0000 | 64'(i));
            vexp[i] = native(i[0], 16'h6000 + 16'(i), 64'hC000_0000_0000_0000 | 64'(i));
        end
        in_valid = 1'b1;
        in_data  = vin[0];
        in_tag   = 9'(0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("b2b", {out_valid, out_tag, out_data}, {1'b1, 9'(i), vexp[i]});
            if (i < 9) begin
                in_data = vin[i+1];
                in_tag  = 9'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        checkOutput("b2b_drain", out_valid, 1'b0);

`ifdef LDE_DENORM_NORMALIZE_EN
        applyStimulus(mem(1'b0, 15'h0, 64'h1), 9'h007);
        tick();
        tick();
`else
        out_ready = 1'b0;
        applyStimulus(mem(1'b0, 15'h3FFF, 64'h8000_0000_0000_0000), 9'h007);
        tick();
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_op", {in_ready, out_valid, out_den, out_tag, out_data}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", in_ready, 1'b1);
        out_ready = 1'b1;
        runNormal("after_reset", mem(1'b1, 15'h3FFE, 64'hFFFF_0000_FFFF_0000), 9'h1FF,
                  native(1'b1, 16'h7FFE, 64'hFFFF_0000_FFFF_0000), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
